memory_store_rv32: RTL and testbench
====================================

Name: memory_store_rv32

Overview:
Store-side counterpart to the load data path of the RV32 core.
- Accepts one store request from the LSU pipeline stage.
- Builds lane-aligned write data and byte strobes, and detects misaligned stores.
- Runs one AXI4-Lite write transaction (AW, W, B) to the data memory or bus.
- Returns a completion response with error flags to the pipeline.

Parameters:
- ADDR_LEN, 32, address width.
- DATA_LEN, 32, data width. Only 32 is supported; strobe width is DATA_LEN/8 = 4.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  store request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  ADDR_LEN  byte address.
- req_data  in  DATA_LEN  store data, right-aligned (rs2).
- is_byte  in  1  SB.
- is_half  in  1  SH.
- is_word  in  1  SW.
- resp_valid  out  1  completion valid.
- resp_ready  in  1  completion consumed.
- resp_misalign  out  1  store address misaligned; no bus access was made.
- resp_bus_err  out  1  BRESP was SLVERR or DECERR.
- awvalid  out  1  AXI write-address valid.
- awready  in  1  AXI write-address ready.
- awaddr  out  ADDR_LEN  AXI write address.
- wvalid  out  1  AXI write-data valid.
- wready  in  1  AXI write-data ready.
- wdata  out  DATA_LEN  AXI write data.
- wstrb  out  DATA_LEN/8  AXI byte strobes.
- bvalid  in  1  AXI write-response valid.
- bready  out  1  AXI write-response ready.
- bresp  in  2  AXI write response.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high on rst.
- State machine: IDLE, SEND, WAIT_B, RESP.
- Reset values: state=IDLE; awvalid=wvalid=bready=resp_valid=0; awaddr=wdata=wstrb=0; resp_misalign=resp_bus_err=0.
- req_ready = (state==IDLE), combinational. It is 1 in the first cycle after reset deassertion.
- Size select priority: is_byte > is_half > is_word.
- IDLE, on accept:
  - No size flag set: go to RESP, both error flags 0, no bus access.
  - Misaligned (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP, resp_misalign=1, no bus access.
  - Otherwise: register awaddr=req_addr, wdata and wstrb; set awvalid=wvalid=1; go to SEND.
- Lane rules:
  - Byte: wdata = {4{d[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - Half: wdata = {2{d[15:0]}}, wstrb = 4'b0011 << addr[1:0].
  - Word: wdata = d, wstrb = 4'b1111.
- SEND:
  - awvalid clears in the cycle after its own handshake; wvalid likewise, independently.
  - awaddr, wdata and wstrb hold stable while the corresponding valid is high.
  - When both handshakes are done (including in the same cycle), go to WAIT_B with bready=1.
- WAIT_B:
  - bready=1 only in this state.
  - On bvalid: resp_bus_err = bresp[1]; bready=0; go to RESP.
- RESP:
  - resp_valid=1; flags stay stable until resp_ready.
  - On resp_ready: resp_valid=0, flags cleared, go to IDLE.
  - The next request can be accepted in the following cycle.
- Minimum latency with all slave readies high and bvalid returned in the WAIT_B entry cycle: accept at cycle 0, AW/W handshake at cycle 1, B at cycle 2, resp_valid at cycle 3.
- Misaligned or no-op request: resp_valid in cycle 1 after accept.
- At most one outstanding transaction; no new request is accepted while busy.
- Reset mid-operation: all valids drop the next cycle and state returns to IDLE. The AXI slave shares rst, so the abandoned transaction is also reset on its side.

Decomposition:
- Shared package holds:
  - State encoding localparams (IDLE/SEND/WAIT_B/RESP).
  - BRESP codes (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
  - Strobe base constants per size.
- One combinational sub-module, memory_store_align: inputs addr[1:0], data, size flags; outputs wdata, wstrb, misalign. The top level holds the FSM and registers only.

Test Plan:
- SB, addr 0x8000_0003, data 0x1234_56A5, all readies high, bresp=OKAY -> awaddr=0x8000_0003, wdata=0xA5A5_A5A5, wstrb=4'b1000; resp_valid at cycle 3; both flags 0.
- SH, addr 0x8000_0002, data 0xDEAD_BEEF -> wdata=0xBEEF_BEEF, wstrb=4'b1100; SW, addr 0x8000_0004 -> wstrb=4'b1111, wdata unchanged.
- SW at 0x8000_0001 and SH at 0x8000_0003 -> resp_valid one cycle after accept with resp_misalign=1; awvalid and wvalid never asserted.
- awready low for 3 cycles, wready high -> wvalid high exactly 1 cycle; awvalid held 4 cycles with awaddr stable; bready rises only after the AW handshake; bresp=2'b10 -> resp_bus_err=1.
- resp_ready low for 4 cycles -> resp_valid and flags stable, req_ready=0, a pending req_valid is not accepted until the cycle after resp_ready.
- rst pulsed while in WAIT_B -> next cycle awvalid=wvalid=bready=resp_valid=0, req_ready=1; a following SB completes normally.

Source files
------------

// File: rtl/memory_store_rv32_pkg.sv
// Shared definitions for the RV32 store data path.
// Holds the FSM state encoding, the AXI4-Lite BRESP codes, the base byte
// strobe patterns for each store size, and a helper that classifies BRESP.
package memory_store_rv32_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEND   = 2'd1;
    localparam logic [1:0] ST_WAIT_B = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        SEND   = ST_SEND,
        WAIT_B = ST_WAIT_B,
        RESP   = ST_RESP
    } state_t;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_EXOKAY = 2'b01;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    // Strobe patterns for a lane-0 access; shifted left by addr[1:0].
    localparam logic [3:0] STRB_BYTE = 4'b0001;
    localparam logic [3:0] STRB_HALF = 4'b0011;
    localparam logic [3:0] STRB_WORD = 4'b1111;

    // SLVERR and DECERR both report a failed write.
    function automatic logic bresp_is_err(input logic [1:0] resp);
        return (resp == BRESP_SLVERR) || (resp == BRESP_DECERR);
    endfunction

endpackage

// File: rtl/memory_store_rv32_if.sv
// Bundle of the store unit's pipeline handshake and AXI4-Lite write channels.
// Ports (per signal group):
//   req_*  : store request from the LSU stage (valid/ready, addr, data, size)
//   resp_* : completion back to the pipeline with misalign / bus error flags
//   aw*, w*, b* : AXI4-Lite write address, write data and write response
// Modports:
//   master : the store unit (drives AXI requests, answers the pipeline)
//   slave  : the environment (pipeline stage plus AXI memory/bus)
interface memory_store_rv32_if #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_LEN-1:0]   req_addr;
    logic [DATA_LEN-1:0]   req_data;
    logic                  is_byte;
    logic                  is_half;
    logic                  is_word;

    logic                  resp_valid;
    logic                  resp_ready;
    logic                  resp_misalign;
    logic                  resp_bus_err;

    logic                  awvalid;
    logic                  awready;
    logic [ADDR_LEN-1:0]   awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_LEN-1:0]   wdata;
    logic [DATA_LEN/8-1:0] wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    modport master (
        input  req_valid, req_addr, req_data, is_byte, is_half, is_word,
        output req_ready,
        output resp_valid, resp_misalign, resp_bus_err,
        input  resp_ready,
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
        input  awready, wready, bvalid, bresp
    );

    modport slave (
        output req_valid, req_addr, req_data, is_byte, is_half, is_word,
        input  req_ready,
        input  resp_valid, resp_misalign, resp_bus_err,
        output resp_ready,
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
        output awready, wready, bvalid, bresp
    );

endinterface

// File: rtl/memory_store_rv32_align.sv
// Combinational lane alignment for RV32 stores.
// Ports:
//   addr_lo  in  low two address bits
//   data     in  right-aligned store data (rs2)
//   is_byte/is_half/is_word in  size flags, priority byte > half > word
//   wdata    out data replicated across all lanes of the access size
//   wstrb    out byte strobes for the addressed lanes
//   misalign out half/word store not naturally aligned
// With no size flag set all outputs are zero.
module memory_store_align
    import memory_store_rv32_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic [1:0]            addr_lo,
    input  logic [DATA_LEN-1:0]   data,
    input  logic                  is_byte,
    input  logic                  is_half,
    input  logic                  is_word,
    output logic [DATA_LEN-1:0]   wdata,
    output logic [DATA_LEN/8-1:0] wstrb,
    output logic                  misalign
);

    // Replicating the data into every lane lets the strobes alone pick the
    // bytes written, so no data shifter is needed.
    always_comb begin
        wdata    = '0;
        wstrb    = '0;
        misalign = 1'b0;
        if (is_byte) begin
            wdata = {4{data[7:0]}};
            wstrb = STRB_BYTE << addr_lo;
        end else if (is_half) begin
            wdata    = {2{data[15:0]}};
            wstrb    = STRB_HALF << addr_lo;
            misalign = addr_lo[0];
        end else if (is_word) begin
            wdata    = data;
            wstrb    = STRB_WORD;
            misalign = |addr_lo;
        end
    end

endmodule

// File: rtl/memory_store_rv32.sv
// Store-side data path of the RV32 core.
// Accepts one store request, issues a single AXI4-Lite write (AW, W, B) and
// returns a completion with misalign / bus error flags.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  master modport of memory_store_rv32_if (pipeline + AXI write)
module memory_store_rv32
    import memory_store_rv32_pkg::*;
#(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    memory_store_rv32_if.master  bus
);

    state_t                state, state_n;
    logic                  awvalid_q, awvalid_n;
    logic                  wvalid_q, wvalid_n;
    logic [ADDR_LEN-1:0]   awaddr_q, awaddr_n;
    logic [DATA_LEN-1:0]   wdata_q, wdata_n;
    logic [DATA_LEN/8-1:0] wstrb_q, wstrb_n;
    logic                  misalign_q, misalign_n;
    logic                  bus_err_q, bus_err_n;

    logic [DATA_LEN-1:0]   al_wdata;
    logic [DATA_LEN/8-1:0] al_wstrb;
    logic                  al_misalign;
    logic                  size_any;

    memory_store_align #(
        .DATA_LEN (DATA_LEN)
    ) u_align (
        .addr_lo  (bus.req_addr[1:0]),
        .data     (bus.req_data),
        .is_byte  (bus.is_byte),
        .is_half  (bus.is_half),
        .is_word  (bus.is_word),
        .wdata    (al_wdata),
        .wstrb    (al_wstrb),
        .misalign (al_misalign)
    );

    assign size_any = bus.is_byte | bus.is_half | bus.is_word;

    // Next-state and next-register logic. Every register holds by default,
    // which keeps awaddr/wdata/wstrb stable while their valids are pending.
    always_comb begin
        state_n    = state;
        awvalid_n  = awvalid_q;
        wvalid_n   = wvalid_q;
        awaddr_n   = awaddr_q;
        wdata_n    = wdata_q;
        wstrb_n    = wstrb_q;
        misalign_n = misalign_q;
        bus_err_n  = bus_err_q;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (!size_any) begin
                        state_n = RESP;
                    end else if (al_misalign) begin
                        misalign_n = 1'b1;
                        state_n    = RESP;
                    end else begin
                        awaddr_n  = bus.req_addr;
                        wdata_n   = al_wdata;
                        wstrb_n   = al_wstrb;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        state_n   = SEND;
                    end
                end
            end
            SEND: begin
                // AW and W complete independently; leave once both are done.
                if (awvalid_q && bus.awready) awvalid_n = 1'b0;
                if (wvalid_q && bus.wready)   wvalid_n  = 1'b0;
                if (!awvalid_n && !wvalid_n)  state_n   = WAIT_B;
            end
            WAIT_B: begin
                if (bus.bvalid) begin
                    bus_err_n = bresp_is_err(bus.bresp);
                    state_n   = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    misalign_n = 1'b0;
                    bus_err_n  = 1'b0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and output registers; reset drops every valid and clears data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state      <= state_n;
            awvalid_q  <= awvalid_n;
            wvalid_q   <= wvalid_n;
            awaddr_q   <= awaddr_n;
            wdata_q    <= wdata_n;
            wstrb_q    <= wstrb_n;
            misalign_q <= misalign_n;
            bus_err_q  <= bus_err_n;
        end
    end

    // bready and resp_valid are pure state decodes of a registered state.
    assign bus.req_ready     = (state == IDLE);
    assign bus.bready        = (state == WAIT_B);
    assign bus.resp_valid    = (state == RESP);
    assign bus.awvalid       = awvalid_q;
    assign bus.wvalid        = wvalid_q;
    assign bus.awaddr        = awaddr_q;
    assign bus.wdata         = wdata_q;
    assign bus.wstrb         = wstrb_q;
    assign bus.resp_misalign = misalign_q;
    assign bus.resp_bus_err  = bus_err_q;

endmodule

// File: tb/tb_memory_store_rv32.sv
// Self-checking bench for memory_store_rv32: directed store vectors with
// hand-computed lane data, strobes, latencies and response flags.
module tb_memory_store_rv32;
    import memory_store_rv32_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    memory_store_rv32_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus_if ();

    memory_store_rv32 #(
        .ADDR_LEN (32),
        .DATA_LEN (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int check_count = 0;
    int error_count = 0;

    int          obs_aw_cnt, obs_w_cnt, obs_resp_cnt, obs_resp_cycle;
    logic [31:0] obs_awaddr, obs_wdata;
    logic [3:0]  obs_wstrb;
    logic        obs_misalign, obs_bus_err;
    logic        obs_aw_unstable, obs_w_unstable, obs_flag_unstable;
    logic        obs_bready_early, obs_ready_busy, obs_done;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Issue one store at a negedge and play the AXI slave and pipeline
    // consumer until the completion is taken, recording what was seen.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic sb, input logic sh, input logic sw,
                                 input int aw_stall, input int w_stall, input int resp_stall,
                                 input logic [1:0] bresp_val, input logic hold_req);
        bit aw_done;
        aw_done           = 0;
        obs_aw_cnt        = 0;
        obs_w_cnt         = 0;
        obs_resp_cnt      = 0;
        obs_resp_cycle    = -1;
        obs_awaddr        = '0;
        obs_wdata         = '0;
        obs_wstrb         = '0;
        obs_misalign      = 1'b0;
        obs_bus_err       = 1'b0;
        obs_aw_unstable   = 1'b0;
        obs_w_unstable    = 1'b0;
        obs_flag_unstable = 1'b0;
        obs_bready_early  = 1'b0;
        obs_ready_busy    = 1'b0;
        obs_done          = 1'b0;

        checkOutput("req_ready_idle", bus_if.req_ready, 1);
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = addr;
        bus_if.req_data  = data;
        bus_if.is_byte   = sb;
        bus_if.is_half   = sh;
        bus_if.is_word   = sw;
        @(posedge clk);

        for (int cyc = 1; cyc <= 40 && !obs_done; cyc++) begin
            @(negedge clk);
            if (!hold_req) bus_if.req_valid = 1'b0;

            if (bus_if.awvalid) begin
                obs_aw_cnt++;
                if (obs_aw_cnt == 1) obs_awaddr = bus_if.awaddr;
                else if (bus_if.awaddr !== obs_awaddr) obs_aw_unstable = 1'b1;
            end
            if (bus_if.wvalid) begin
                obs_w_cnt++;
                if (obs_w_cnt == 1) begin
                    obs_wdata = bus_if.wdata;
                    obs_wstrb = bus_if.wstrb;
                end else if (bus_if.wdata !== obs_wdata || bus_if.wstrb !== obs_wstrb) begin
                    obs_w_unstable = 1'b1;
                end
            end
            if (bus_if.bready && !aw_done) obs_bready_early = 1'b1;
            if (hold_req && bus_if.req_ready) obs_ready_busy = 1'b1;
            if (bus_if.resp_valid) begin
                obs_resp_cnt++;
                if (obs_resp_cnt == 1) begin
                    obs_resp_cycle = cyc;
                    obs_misalign   = bus_if.resp_misalign;
                    obs_bus_err    = bus_if.resp_bus_err;
                end else if (bus_if.resp_misalign !== obs_misalign ||
                             bus_if.resp_bus_err !== obs_bus_err) begin
                    obs_flag_unstable = 1'b1;
                end
            end

            bus_if.awready = bus_if.awvalid && (obs_aw_cnt > aw_stall);
            if (bus_if.awready) aw_done = 1;
            bus_if.wready     = bus_if.wvalid && (obs_w_cnt > w_stall);
            bus_if.bvalid     = bus_if.bready;
            bus_if.bresp      = bresp_val;
            bus_if.resp_ready = bus_if.resp_valid && (obs_resp_cnt > resp_stall);
            if (bus_if.resp_ready) begin
                obs_done = 1'b1;
                @(posedge clk);
            end
        end
        if (!obs_done) checkOutput("txn_timeout", 0, 1);

        @(negedge clk);
        bus_if.awready    = 1'b0;
        bus_if.wready     = 1'b0;
        bus_if.bvalid     = 1'b0;
        bus_if.bresp      = BRESP_OKAY;
        bus_if.resp_ready = 1'b0;
        checkOutput("resp_cleared",
                    {29'd0, bus_if.resp_valid, bus_if.resp_misalign, bus_if.resp_bus_err}, 0);
        checkOutput("req_ready_after", bus_if.req_ready, 1);
    endtask

    initial begin
        rst               = 1'b1;
        bus_if.req_valid  = 1'b0;
        bus_if.req_addr   = '0;
        bus_if.req_data   = '0;
        bus_if.is_byte    = 1'b0;
        bus_if.is_half    = 1'b0;
        bus_if.is_word    = 1'b0;
        bus_if.resp_ready = 1'b0;
        bus_if.awready    = 1'b0;
        bus_if.wready     = 1'b0;
        bus_if.bvalid     = 1'b0;
        bus_if.bresp      = BRESP_OKAY;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_valids",
                    {28'd0, bus_if.awvalid, bus_if.wvalid, bus_if.bready, bus_if.resp_valid}, 0);
        checkOutput("rst_awaddr", bus_if.awaddr, 0);
        checkOutput("rst_wdata", bus_if.wdata, 0);
        checkOutput("rst_wstrb", {28'd0, bus_if.wstrb}, 0);
        checkOutput("rst_flags", {30'd0, bus_if.resp_misalign, bus_if.resp_bus_err}, 0);
        rst = 1'b0;
        checkOutput("rst_req_ready", bus_if.req_ready, 1);

        $display("[TB] SB min latency");
        applyStimulus(32'h8000_0003, 32'h1234_56A5, 1, 0, 0, 0, 0, 0, BRESP_OKAY, 0);
        checkOutput("sb_awaddr", obs_awaddr, 32'h8000_0003);
        checkOutput("sb_wdata", obs_wdata, 32'hA5A5_A5A5);
        checkOutput("sb_wstrb", {28'd0, obs_wstrb}, 32'h8);
        checkOutput("sb_aw_cnt", obs_aw_cnt, 1);
        checkOutput("sb_w_cnt", obs_w_cnt, 1);
        checkOutput("sb_resp_cycle", obs_resp_cycle, 3);
        checkOutput("sb_flags", {30'd0, obs_misalign, obs_bus_err}, 0);

        $display("[TB] SH and SW lanes");
        applyStimulus(32'h8000_0002, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0, BRESP_OKAY, 0);
        checkOutput("sh_wdata", obs_wdata, 32'hBEEF_BEEF);
        checkOutput("sh_wstrb", {28'd0, obs_wstrb}, 32'hC);
        checkOutput("sh_resp_cycle", obs_resp_cycle, 3);
        applyStimulus(32'h8000_0004, 32'hDEAD_BEEF, 0, 0, 1, 0, 0, 0, BRESP_EXOKAY, 0);
        checkOutput("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
        checkOutput("sw_wstrb", {28'd0, obs_wstrb}, 32'hF);
        checkOutput("sw_awaddr", obs_awaddr, 32'h8000_0004);
        checkOutput("sw_flags", {30'd0, obs_misalign, obs_bus_err}, 0);

        $display("[TB] size priority and no-op");
        applyStimulus(32'h8000_0001, 32'h0000_00C3, 1, 0, 1, 0, 0, 0, BRESP_OKAY, 0);
        checkOutput("prio_wdata", obs_wdata, 32'hC3C3_C3C3);
        checkOutput("prio_wstrb", {28'd0, obs_wstrb}, 32'h2);
        checkOutput("prio_misalign", obs_misalign, 0);
        applyStimulus(32'h8000_0003, 32'h1111_1111, 0, 0, 0, 0, 0, 0, BRESP_OKAY, 0);
        checkOutput("noop_resp_cycle", obs_resp_cycle, 1);
        checkOutput("noop_bus", obs_aw_cnt + obs_w_cnt, 0);
        checkOutput("noop_flags", {30'd0, obs_misalign, obs_bus_err}, 0);

        $display("[TB] misaligned stores");
        applyStimulus(32'h8000_0001, 32'h0BAD_F00D, 0, 0, 1, 0, 0, 0, BRESP_OKAY, 0);
        checkOutput("sw_mis_cycle", obs_resp_cycle, 1);
        checkOutput("sw_mis_flags", {30'd0, obs_misalign, obs_bus_err}, 2);
        checkOutput("sw_mis_bus", obs_aw_cnt + obs_w_cnt, 0);
        applyStimulus(32'h8000_0003, 32'h0BAD_F00D, 0, 1, 0, 0, 0, 0, BRESP_OKAY, 0);
        checkOutput("sh_mis_cycle", obs_resp_cycle, 1);
        checkOutput("sh_mis_flags", {30'd0, obs_misalign, obs_bus_err}, 2);
        checkOutput("sh_mis_bus", obs_aw_cnt + obs_w_cnt, 0);

        $display("[TB] AW stall with SLVERR");
        applyStimulus(32'h8000_0001, 32'h0000_005A, 1, 0, 0, 3, 0, 0, BRESP_SLVERR, 0);
        checkOutput("stall_aw_cnt", obs_aw_cnt, 4);
        checkOutput("stall_w_cnt", obs_w_cnt, 1);
        checkOutput("stall_aw_stable", obs_aw_unstable, 0);
        checkOutput("stall_awaddr", obs_awaddr, 32'h8000_0001);
        checkOutput("stall_wstrb", {28'd0, obs_wstrb}, 32'h2);
        checkOutput("stall_bready_early", obs_bready_early, 0);
        checkOutput("stall_resp_cycle", obs_resp_cycle, 6);
        checkOutput("stall_bus_err", obs_bus_err, 1);

        $display("[TB] W stall");
        applyStimulus(32'h8000_0010, 32'h0000_9876, 0, 1, 0, 0, 2, 0, BRESP_OKAY, 0);
        checkOutput("wst_w_cnt", obs_w_cnt, 3);
        checkOutput("wst_aw_cnt", obs_aw_cnt, 1);
        checkOutput("wst_w_stable", obs_w_unstable, 0);
        checkOutput("wst_wdata", obs_wdata, 32'h9876_9876);
        checkOutput("wst_resp_cycle", obs_resp_cycle, 5);

        $display("[TB] response back-pressure");
        applyStimulus(32'h8000_0008, 32'h0102_0304, 0, 0, 1, 0, 0, 4, BRESP_DECERR, 1);
        checkOutput("bp_resp_cnt", obs_resp_cnt, 5);
        checkOutput("bp_flag_stable", obs_flag_unstable, 0);
        checkOutput("bp_bus_err", obs_bus_err, 1);
        checkOutput("bp_ready_busy", obs_ready_busy, 0);

        $display("[TB] pending request after back-pressure");
        applyStimulus(32'h8000_0006, 32'h0000_ABCD, 0, 1, 0, 0, 0, 0, BRESP_OKAY, 0);
        checkOutput("pend_wdata", obs_wdata, 32'hABCD_ABCD);
        checkOutput("pend_wstrb", {28'd0, obs_wstrb}, 32'hC);
        checkOutput("pend_resp_cycle", obs_resp_cycle, 3);

        $display("[TB] reset during WAIT_B");
        checkOutput("rw_req_ready", bus_if.req_ready, 1);
        bus_if.req_valid = 1'b1;
        bus_if.req_addr  = 32'h8000_000C;
        bus_if.req_data  = 32'hCAFE_F00D;
        bus_if.is_byte   = 1'b0;
        bus_if.is_half   = 1'b0;
        bus_if.is_word   = 1'b1;
        bus_if.awready   = 1'b1;
        bus_if.wready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        checkOutput("rw_send", {30'd0, bus_if.awvalid, bus_if.wvalid}, 3);
        @(negedge clk);
        checkOutput("rw_waitb", bus_if.bready, 1);
        rst            = 1'b1;
        bus_if.awready = 1'b0;
        bus_if.wready  = 1'b0;
        @(negedge clk);
        checkOutput("rw_valids",
                    {28'd0, bus_if.awvalid, bus_if.wvalid, bus_if.bready, bus_if.resp_valid}, 0);
        checkOutput("rw_idle", bus_if.req_ready, 1);
        rst = 1'b0;
        applyStimulus(32'h8000_0000, 32'h0000_0077, 1, 0, 0, 0, 0, 0, BRESP_OKAY, 0);
        checkOutput("post_rst_wdata", obs_wdata, 32'h7777_7777);
        checkOutput("post_rst_wstrb", {28'd0, obs_wstrb}, 32'h1);
        checkOutput("post_rst_cycle", obs_resp_cycle, 3);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
